// File: rtl/mc14500b_program_loader.sv
// Byte-stream program loader for the MC14500B core: assembles 12-bit words from
// header/low byte pairs, drives the core load port and sequences the core reset.
module mc14500b_program_loader #(
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned WRITE_GAP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        core_rst,
    output logic        program_write,
    output logic [11:0] program_cmd,
    output logic [8:0]  word_count,
    output logic        loaded,
    output logic        error
);

    typedef enum logic [2:0] {
        StInitRst,
        StWaitHi,
        StWaitLo,
        StWrite,
        StGap,
        StStartRst,
        StRun,
        StError
    } state_e;

    localparam logic [15:0] RstLast = 16'(RST_CYCLES - 1);
    localparam logic [15:0] GapLast = 16'(WRITE_GAP - 1);
    localparam logic [8:0]  MaxWc   = 9'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  hi_q, hi_d;
    logic [11:0] cmd_q, cmd_d;
    logic [8:0]  wc_q, wc_d;
    logic [1:0]  sync_q;
    logic        in_ready_q, core_rst_q, write_q, loaded_q, error_q;
    logic        accept;

    // Assertion is immediate; release reaches the FSM two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        cmd_d   = cmd_q;
        wc_d    = wc_q;
        unique case (state_q)
            StInitRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitHi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitHi: begin
                if (accept) begin
                    if (in_data == 8'hFF) begin
                        state_d = StStartRst;
                        cnt_d   = '0;
                    end else if (in_data[7:4] == 4'h0) begin
                        if (wc_q == MaxWc) begin
                            state_d = StError;
                        end else begin
                            hi_d    = in_data[3:0];
                            state_d = StWaitLo;
                        end
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StWaitLo: begin
                if (accept) begin
                    cmd_d   = {hi_q, in_data};
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wc_q != MaxWc) begin
                    wc_d = wc_q + 9'd1;
                end
                if (WRITE_GAP == 0) begin
                    state_d = StWaitHi;
                end else begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StWaitHi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStartRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun:   state_d = StRun;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // Outputs are registered from the next state so they always match state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInitRst;
            cnt_q      <= '0;
            hi_q       <= '0;
            cmd_q      <= '0;
            wc_q       <= '0;
            in_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            write_q    <= 1'b0;
            loaded_q   <= 1'b0;
            error_q    <= 1'b0;
        end else if (!sync_q[1]) begin
            state_q    <= StInitRst;
            cnt_q      <= '0;
            hi_q       <= '0;
            cmd_q      <= '0;
            wc_q       <= '0;
            in_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            write_q    <= 1'b0;
            loaded_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            cmd_q      <= cmd_d;
            wc_q       <= wc_d;
            in_ready_q <= (state_d == StWaitHi) || (state_d == StWaitLo);
            core_rst_q <= (state_d == StInitRst) || (state_d == StStartRst) ||
                          (state_d == StError);
            write_q    <= (state_d == StWrite);
            loaded_q   <= (state_d == StRun);
            error_q    <= (state_d == StError);
        end
    end

    assign in_ready      = in_ready_q;
    assign core_rst      = core_rst_q;
    assign program_write = write_q;
    assign program_cmd   = cmd_q;
    assign word_count    = wc_q;
    assign loaded        = loaded_q;
    assign error         = error_q;

endmodule

// File: tb/tb_mc14500b_program_loader.sv
// Self-checking bench: byte streams with random valid toggling against a
// stream-level model of the load protocol.
module tb_mc14500b_program_loader;

    localparam int unsigned MaxWords  = 4;
    localparam int unsigned RstCycles = 2;
    localparam int unsigned WriteGap  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, core_rst, program_write, loaded, error;
    logic [11:0] program_cmd;
    logic [8:0]  word_count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  stim[$];
    logic [11:0] exp_cmd[$];
    logic [11:0] obs_cmd[$];
    int          exp_consumed;
    int          exp_wc;
    bit          exp_loaded;
    bit          prev_wr = 1'b0;

    mc14500b_program_loader #(
        .MAX_WORDS (MaxWords),
        .RST_CYCLES(RstCycles),
        .WRITE_GAP (WriteGap)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .core_rst     (core_rst),
        .program_write(program_write),
        .program_cmd  (program_cmd),
        .word_count   (word_count),
        .loaded       (loaded),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write pulse: capture command, check count lags by one, no overlap with reset.
    always @(negedge clk) begin
        if (rst_n && program_write) begin
            check("wc_at_write", 32'(word_count), 32'(obs_cmd.size()));
            check("wr_rst_excl", 32'(core_rst), 32'd0);
            check("wr_single", 32'(prev_wr), 32'd0);
            obs_cmd.push_back(program_cmd);
        end
        prev_wr = program_write;
    end

    // Decode the byte stream from the protocol rules alone.
    task automatic model();
        int i;
        int wc;
        logic [7:0] b;
        exp_cmd.delete();
        wc = 0;
        exp_loaded = 1'b0;
        exp_consumed = stim.size();
        i = 0;
        while (i < stim.size()) begin
            b = stim[i];
            if (b == 8'hFF) begin
                exp_loaded = 1'b1;
                exp_consumed = i + 1;
                break;
            end else if (b[7:4] != 4'h0 || wc == MaxWords) begin
                exp_consumed = i + 1;
                break;
            end
            exp_cmd.push_back({b[3:0], stim[i+1]});
            wc++;
            i += 2;
        end
        exp_wc = wc;
    endtask

    task automatic do_reset();
        int k;
        in_valid = 1'b0;
        rst_n = 1'b0;
        obs_cmd.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_write", 32'(program_write), 32'd0);
        check("rst_cmd", 32'(program_cmd), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_flags", 32'({loaded, error}), 32'd0);
        rst_n = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("init_ready_seen", 32'(in_ready), 32'd1);
        check("init_rst_low", 32'(core_rst), 32'd0);
    endtask

    task automatic run_stream(input string name, input int pct);
        int idx;
        int cyc;
        int width;
        bit v;
        model();
        idx = 0;
        cyc = 0;
        while (idx < exp_consumed && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            v = ($urandom_range(99) < pct);
            in_valid = v;
            in_data = stim[idx];
            if (v && in_ready) idx++;
        end
        if (idx < exp_consumed) check({name, "_drv_timeout"}, 32'(idx), 32'(exp_consumed));
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'h00;
        if (exp_loaded) begin
            width = 0;
            while (core_rst && width < 20) begin
                width++;
                @(negedge clk);
            end
            check({name, "_start_rst_w"}, 32'(width), 32'(RstCycles));
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
            check({name, "_err_core_rst"}, 32'(core_rst), 32'd1);
        end
        check({name, "_loaded"}, 32'(loaded), 32'(exp_loaded));
        check({name, "_error"}, 32'(error), 32'(!exp_loaded));
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_wc"}, 32'(word_count), 32'(exp_wc));
        check({name, "_n_writes"}, 32'(obs_cmd.size()), 32'(exp_cmd.size()));
        for (int j = 0; j < exp_cmd.size() && j < obs_cmd.size(); j++)
            check({name, "_cmd"}, 32'(obs_cmd[j]), 32'(exp_cmd[j]));
    endtask

    initial begin
        // Basic two-word program, valid always high.
        do_reset();
        stim = '{8'h00, 8'h12, 8'h03, 8'h4A, 8'hFF};
        run_stream("basic", 100);
        check("basic_cmd0", 32'(obs_cmd.size() > 0 ? obs_cmd[0] : 12'hFFF), 32'h012);
        check("basic_cmd1", 32'(obs_cmd.size() > 1 ? obs_cmd[1] : 12'hFFF), 32'h34A);

        // Same stream with random valid gaps.
        do_reset();
        stim = '{8'h00, 8'h12, 8'h03, 8'h4A, 8'hFF};
        run_stream("gappy", 40);

        // Bad header after one word.
        do_reset();
        stim = '{8'h00, 8'h12, 8'h20, 8'h00};
        run_stream("badhdr", 100);

        // Overflow: five words into a four-word memory.
        do_reset();
        stim = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44, 8'h05, 8'h55, 8'hFF};
        run_stream("ovf", 100);

        // Zero-word program.
        do_reset();
        stim = '{8'hFF};
        run_stream("zero", 100);

        // Reset between header and low byte discards the partial word.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h05;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_in_wait_lo", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_rst", 32'({in_ready, core_rst, program_write, loaded, error}),
              32'b01000);
        check("mid_async_cmd_wc", 32'({program_cmd, word_count}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int k;
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        obs_cmd.delete();
        stim = '{8'h01, 8'hFF, 8'hFF};
        run_stream("reload", 70);
        check("reload_cmd", 32'(program_cmd), 32'h1FF);

        // Random streams.
        for (int t = 0; t < 25; t++) begin
            int nw;
            logic [7:0] h;
            do_reset();
            stim.delete();
            nw = $urandom_range(0, 5);
            for (int w = 0; w < nw; w++) begin
                h = 8'($urandom_range(0, 15));
                stim.push_back(h);
                stim.push_back(8'($urandom_range(0, 255)));
            end
            if ($urandom_range(3) == 0) begin
                h = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
                if (h == 8'hFF) h = 8'hF0;
                stim.push_back(h);
            end else begin
                stim.push_back(8'hFF);
            end
            stim.push_back(8'($urandom_range(0, 255)));
            run_stream("rand", $urandom_range(30, 100));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
